// File: rtl/led_scan_decoder.sv
// Receive-side decoder for the bouncing one-hot LED scanner bus: tracks position, direction and end-stop bounces.
// Optional `LED_SCAN_RESYNC_EN: saturating error counter and ERROR -> TRACK recovery on the next legal sample.
module led_scan_decoder #(
  parameter int unsigned BOUNCE_W = 8
) (
  input  logic                inclk,
  input  logic                reset,
  input  logic [7:0]          led,
  input  logic                led_valid,
  output logic [2:0]          pos,
  output logic                pos_valid,
  output logic                dir,
  output logic                step,
  output logic                bounce,
  output logic [BOUNCE_W-1:0] bounce_count,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  localparam logic [BOUNCE_W-1:0] COUNT_ONE = {{(BOUNCE_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [2:0]          pos_nxt;
  logic                pos_valid_nxt;
  logic                dir_nxt;
  logic                dir_known, dir_known_nxt;
  logic                step_nxt;
  logic                bounce_nxt;
  logic [BOUNCE_W-1:0] bounce_count_nxt;
  logic                err_nxt;
  logic                enter_err;

  logic                one_hot;
  logic [2:0]          idx;
  logic                move_up, move_down, new_dir, at_end;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (led[i]) idx = i[2:0];
    end
  end

  assign one_hot   = (led != '0) && ((led & (led - 8'd1)) == '0);
  assign move_up   = (pos != 3'd7) && (idx == pos + 3'd1);
  assign move_down = (pos != 3'd0) && (idx == pos - 3'd1);
  assign new_dir   = move_down;
  // A reversal is only legal when leaving the end the scanner was travelling toward.
  assign at_end    = ((pos == 3'd7) && !dir) || ((pos == 3'd0) && dir);

  always_comb begin
    state_nxt        = state;
    pos_nxt          = pos;
    pos_valid_nxt    = pos_valid;
    dir_nxt          = dir;
    dir_known_nxt    = dir_known;
    step_nxt         = 1'b0;
    bounce_nxt       = 1'b0;
    bounce_count_nxt = bounce_count;
    err_nxt          = err;
    enter_err        = 1'b0;

    case (state)
      IDLE: begin
        if (led_valid) begin
          if (one_hot) begin
            pos_nxt       = idx;
            pos_valid_nxt = 1'b1;
            state_nxt     = TRACK;
          end else begin
            enter_err = 1'b1;
          end
        end
      end
      TRACK: begin
        if (led_valid) begin
          if (!one_hot) begin
            enter_err = 1'b1;
          end else if (idx == pos) begin
            state_nxt = TRACK;
          end else if (move_up || move_down) begin
            if (!dir_known) begin
              pos_nxt       = idx;
              step_nxt      = 1'b1;
              dir_nxt       = new_dir;
              dir_known_nxt = 1'b1;
            end else if (new_dir == dir) begin
              pos_nxt  = idx;
              step_nxt = 1'b1;
            end else if (at_end) begin
              pos_nxt    = idx;
              step_nxt   = 1'b1;
              dir_nxt    = new_dir;
              bounce_nxt = 1'b1;
              if (bounce_count != '1) bounce_count_nxt = bounce_count + COUNT_ONE;
            end else begin
              enter_err = 1'b1;
            end
          end else begin
            enter_err = 1'b1;
          end
        end
      end
      ERROR: begin
`ifdef LED_SCAN_RESYNC_EN
        if (led_valid && one_hot) begin
          pos_nxt       = idx;
          pos_valid_nxt = 1'b1;
          dir_known_nxt = 1'b0;
          state_nxt     = TRACK;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    if (enter_err) begin
      err_nxt       = 1'b1;
      pos_valid_nxt = 1'b0;
      state_nxt     = ERROR;
    end
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state        <= IDLE;
      pos          <= '0;
      pos_valid    <= 1'b0;
      dir          <= 1'b0;
      dir_known    <= 1'b0;
      step         <= 1'b0;
      bounce       <= 1'b0;
      bounce_count <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      pos          <= pos_nxt;
      pos_valid    <= pos_valid_nxt;
      dir          <= dir_nxt;
      dir_known    <= dir_known_nxt;
      step         <= step_nxt;
      bounce       <= bounce_nxt;
      bounce_count <= bounce_count_nxt;
      err          <= err_nxt;
    end
  end

`ifdef LED_SCAN_RESYNC_EN
  logic [BOUNCE_W-1:0] err_count;

  always_ff @(posedge inclk) begin
    if (reset) begin
      err_count <= '0;
    end else if (enter_err && (err_count != '1)) begin
      err_count <= err_count + COUNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed self-checking bench for led_scan_decoder with hand-computed expectations.
// Honours `LED_SCAN_RESYNC_EN for the recovery-after-error step.
module tb_led_scan_decoder;

  logic       inclk;
  logic       reset;
  logic [7:0] led;
  logic       led_valid;
  logic [2:0] pos;
  logic       pos_valid;
  logic       dir;
  logic       step;
  logic       bounce;
  logic [7:0] bounce_count;
  logic       err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  led_scan_decoder #(.BOUNCE_W(8)) dut (
    .inclk        (inclk),
    .reset        (reset),
    .led          (led),
    .led_valid    (led_valid),
    .pos          (pos),
    .pos_valid    (pos_valid),
    .dir          (dir),
    .step         (step),
    .bounce       (bounce),
    .bounce_count (bounce_count),
    .err          (err)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the sample registered.
  task automatic send(input logic [7:0] v);
    led       = v;
    led_valid = 1'b1;
    @(negedge inclk);
    led_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge inclk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pos"}, 32'(pos), 32'd0);
    chk({tag, "_pos_valid"}, 32'(pos_valid), 32'd0);
    chk({tag, "_dir"}, 32'(dir), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_bounce"}, 32'(bounce), 32'd0);
    chk({tag, "_bounce_count"}, 32'(bounce_count), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int         p;
    bit         up;

    reset     = 1'b1;
    led       = 8'h00;
    led_valid = 1'b0;
    repeat (2) @(negedge inclk);
    chk_reset_state("reset");
    reset = 1'b0;

    // Sweep from bit 7 down to bit 0, then bounce back to bit 1.
    for (int i = 7; i >= 0; i--) begin
      v = 8'h01 << i;
      send(v);
      chk("sweep_pos", 32'(pos), 32'(i));
      chk("sweep_pos_valid", 32'(pos_valid), 32'd1);
      if (i == 7) chk("sweep_first_step", 32'(step), 32'd0);
      if (i == 6) begin
        chk("sweep_dir_after_first", 32'(dir), 32'd1);
        chk("sweep_step", 32'(step), 32'd1);
        chk("sweep_no_bounce_first", 32'(bounce), 32'd0);
      end
      if (i == 0) chk("sweep_no_bounce_at_0", 32'(bounce), 32'd0);
    end
    send(8'h02);
    chk("bounce_pos", 32'(pos), 32'd1);
    chk("bounce_pulse", 32'(bounce), 32'd1);
    chk("bounce_dir", 32'(dir), 32'd0);
    chk("bounce_count1", 32'(bounce_count), 32'd1);
    chk("bounce_err", 32'(err), 32'd0);
    @(negedge inclk);
    chk("bounce_pulse_clears", 32'(bounce), 32'd0);
    chk("step_pulse_clears", 32'(step), 32'd0);
    chk("hold_pos", 32'(pos), 32'd1);

    // Stall then move.
    do_reset();
    send(8'h10);
    chk("stall_first_pos", 32'(pos), 32'd4);
    send(8'h10);
    chk("stall_no_step", 32'(step), 32'd0);
    chk("stall_pos", 32'(pos), 32'd4);
    send(8'h20);
    chk("stall_move_pos", 32'(pos), 32'd5);
    chk("stall_move_step", 32'(step), 32'd1);
    chk("stall_move_dir", 32'(dir), 32'd0);

    // Non-one-hot sample while tracking.
    do_reset();
    send(8'h08);
    send(8'h18);
    chk("shape_err", 32'(err), 32'd1);
    chk("shape_pos_valid", 32'(pos_valid), 32'd0);
    chk("shape_pos", 32'(pos), 32'd3);
    send(8'h04);
`ifdef LED_SCAN_RESYNC_EN
    chk("resync_pos", 32'(pos), 32'd2);
    chk("resync_pos_valid", 32'(pos_valid), 32'd1);
`else
    chk("absorb_pos", 32'(pos), 32'd3);
    chk("absorb_pos_valid", 32'(pos_valid), 32'd0);
`endif
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_no_step", 32'(step), 32'd0);

    // Reversal away from the ends.
    do_reset();
    send(8'h08);
    send(8'h10);
    send(8'h08);
    chk("midrev_err", 32'(err), 32'd1);
    chk("midrev_bounce", 32'(bounce), 32'd0);
    chk("midrev_count", 32'(bounce_count), 32'd0);
    chk("midrev_pos", 32'(pos), 32'd4);
    chk("midrev_dir", 32'(dir), 32'd0);

    // No wrap from 0 to 7.
    do_reset();
    send(8'h01);
    send(8'h80);
    chk("jump_err", 32'(err), 32'd1);
    chk("jump_pos", 32'(pos), 32'd0);

    // Empty bus as first sample.
    do_reset();
    send(8'h00);
    chk("zero_err", 32'(err), 32'd1);
    chk("zero_pos_valid", 32'(pos_valid), 32'd0);

    // Reset wins over a simultaneous strobe mid-sweep.
    do_reset();
    send(8'h80);
    send(8'h40);
    send(8'h20);
    chk("midsweep_pos", 32'(pos), 32'd5);
    reset     = 1'b1;
    led       = 8'h40;
    led_valid = 1'b1;
    @(negedge inclk);
    reset     = 1'b0;
    led_valid = 1'b0;
    chk_reset_state("reset_with_valid");
    send(8'h04);
    chk("after_reset_pos", 32'(pos), 32'd2);
    chk("after_reset_pos_valid", 32'(pos_valid), 32'd1);
    chk("after_reset_step", 32'(step), 32'd0);

    // Long bouncing scan: bounce k lands on step 7k+1 counted from bit 0.
    do_reset();
    send(8'h01);
    p  = 0;
    up = 1'b1;
    for (int n = 1; n <= 1793; n++) begin
      if (up && p == 7) up = 1'b0;
      else if (!up && p == 0) up = 1'b1;
      p = up ? p + 1 : p - 1;
      v = 8'h01 << p;
      send(v);
      if (n == 1785) chk("sat_count_254", 32'(bounce_count), 32'd254);
      if (n == 1786) begin
        chk("sat_count_255", 32'(bounce_count), 32'd255);
        chk("sat_bounce_255", 32'(bounce), 32'd1);
      end
    end
    chk("sat_hold_255", 32'(bounce_count), 32'd255);
    chk("sat_bounce_pulse", 32'(bounce), 32'd1);
    chk("sat_err", 32'(err), 32'd0);
    chk("sat_pos", 32'(pos), 32'(p));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
